// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM write-port arbiter and its fill sequencer.
package ram_arb_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 15;
  localparam int LEN_WIDTH_DEF  = 15;
  localparam int STAT_WIDTH     = 16;

  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_HOST, GNT_FILL} grant_e;

  typedef enum logic [1:0] {FILL_IDLE, FILL_RUN, FILL_DONE} fill_state_e;

  // Counters stick at all-ones rather than wrapping back to a misleading small value.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ram_fill_seq.sv
// Fill sequencer: walks cur_addr from the latched base for the latched length,
// advancing only in cycles where the arbiter grants it the write port.
module ram_fill_seq
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [LEN_WIDTH-1:0]  fill_len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  gnt,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  fill_busy,
  output logic                  fill_done
);

  fill_state_e           state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] value;

  assign req  = (state == FILL_RUN);
  assign addr = cur_addr;
  assign data = value;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      value     <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        FILL_IDLE: begin
          if (fill_start) begin
            fill_busy <= 1'b1;
            if (fill_len != '0) begin
              cur_addr  <= fill_base;
              remaining <= fill_len;
              value     <= fill_value;
              state     <= FILL_RUN;
            end else begin
              state     <= FILL_DONE;
              fill_done <= 1'b1;
            end
          end
        end
        FILL_RUN: begin
          if (gnt) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state     <= FILL_DONE;
              fill_done <= 1'b1;
            end
          end
        end
        FILL_DONE: begin
          state     <= FILL_IDLE;
          fill_busy <= 1'b0;
        end
        default: begin
          state     <= FILL_IDLE;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_wr_arbiter.sv
// Fixed-priority owner of the shared RAM write port: CPU > host loader > fill sequencer.
// Optional stall statistics are built when RAM_ARB_STATS_EN is defined.
module ram_wr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [LEN_WIDTH-1:0]  fill_len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_host_stall,
  output logic [STAT_WIDTH-1:0] stat_fill_stall
`endif
);

  grant_e                grant;
  logic                  fill_req;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;

  // The CPU cannot stall, so the host is only ever turned away by a CPU store.
  assign host_ready = !rst && !cpu_we;

  // NOTE: grant gets a default before the priority chain so no latch is inferred.
  always_comb begin
    grant = GNT_NONE;
    if (cpu_we)          grant = GNT_CPU;
    else if (host_valid) grant = GNT_HOST;
    else if (fill_req)   grant = GNT_FILL;
  end

  ram_fill_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_fill_seq (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_value (fill_value),
    .gnt        (grant == GNT_FILL),
    .req        (fill_req),
    .addr       (fill_addr),
    .data       (fill_data),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  // Address/data hold their last value on idle cycles; only ram_we drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ram_we <= (grant != GNT_NONE);
      case (grant)
        GNT_CPU: begin
          ram_addr <= cpu_addr;
          ram_data <= cpu_data;
        end
        GNT_HOST: begin
          ram_addr <= host_addr;
          ram_data <= host_data;
        end
        GNT_FILL: begin
          ram_addr <= fill_addr;
          ram_data <= fill_data;
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_host_stall <= '0;
      stat_fill_stall <= '0;
    end else begin
      if (host_valid && !host_ready)
        stat_host_stall <= sat_inc(stat_host_stall);
      if (fill_req && (grant != GNT_FILL))
        stat_fill_stall <= sat_inc(stat_fill_stall);
    end
  end
`endif

endmodule
